param_sync_fifo: RTL and testbench
==================================

# param_sync_fifo

Parametrised single-clock FIFO, the next generation of the team's sync FIFO, generalised in width and depth. Adds an occupancy count, programmable almost-empty/almost-full thresholds and sticky overflow/underflow flags. An optional first-word-fall-through read mode is selected at compile time. Sits between a producer and consumer in the same clock domain and keeps the existing push/pop/ept/ful/valid handshake.

## Interface
Parameters:
- WIDTH, 8: data width in bits.
- DEPTH, 16: entries; power of two, ≥ 2.
- AE_LVL, 2: almost_ept asserts when level ≤ AE_LVL.
- AF_LVL, DEPTH-2: almost_ful asserts when level ≥ AF_LVL.

Ports:
- clock  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  write request.
- w_data  in  WIDTH  write data, sampled with push.
- pop  in  1  read request / acknowledge.
- r_data  out  WIDTH  read data.
- valid  out  1  r_data qualifier.
- ept  out  1  empty (level == 0).
- ful  out  1  full (level == DEPTH).
- almost_ept  out  1  level ≤ AE_LVL.
- almost_ful  out  1  level ≥ AF_LVL.
- level  out  $clog2(DEPTH)+1  current occupancy.
- ovf  out  1  sticky: push rejected while full.
- udf  out  1  sticky: pop rejected while empty.

## Operation
- Reset values: level=0, ept=1, ful=0, almost_ept=1, almost_ful=0, ovf=0, udf=0, valid=0, r_data=0, pointers=0.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. There is no separate wrap bit; level disambiguates full from empty.
- Accepted push: push & (!ful | pop_acc). Accepted pop: pop & !ept.
- Push while full with no accepted pop: data dropped, ovf set.
- Pop while empty: no state change, udf set.
- Push and pop together when full: both accepted, level unchanged. Pointers both advance.
- Push and pop together when empty: push accepted, pop rejected, udf set.
- level: +1 on push only, −1 on pop only, unchanged when both or neither.
- All flags are registered and derived from the next-state level, so they match level in the same cycle.
- ovf and udf clear only on reset.
- reset asserted mid-operation: contents are discarded. Any push or pop in the reset cycle is ignored. All outputs take their reset values at the next edge.

## Timing
- Push at edge N: level and flags update at N+1. Data is readable from N+1.
- Standard mode: accepted pop at edge N gives the head word on r_data with valid=1 during cycle N+1 (one-cycle pulse). r_data holds its last value while valid=0.
- Rejected pop never raises valid.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- PARAM_SYNC_FIFO_FWFT_EN defined: first-word-fall-through mode.
  - r_data combinationally shows the head entry and valid = !ept.
  - pop acts as an acknowledge that consumes the shown word at the edge.
  - Push at N gives valid=1 from N+1 with no pop needed.
  - r_data is 0 when empty after reset.
- Undefined: standard registered-read mode as described under Timing.
- All other behaviour, flag timing and level arithmetic are identical in both modes.

## Structure
- Package param_sync_fifo_pkg holds:
  - the pointer/level width function (clog2-based).
  - a typedef for the status bundle {ept, ful, almost_ept, almost_ful, ovf, udf}.
- Sub-module param_sync_fifo_mem: DEPTH×WIDTH storage with synchronous write and asynchronous read by address. No reset on storage.
- The top holds pointers, level, flags and the read register.

## Test plan
- DEPTH=4, AE_LVL=1, AF_LVL=3; push 0xA1,0xA2,0xA3,0xA4 on consecutive cycles:
  - level 1,2,3,4.
  - almost_ful rises with level=3.
  - ful=1 after the 4th push.
  - ept=0 after the 1st push.
- From full, push 0xFF alone → ovf=1, level stays 4. Then pop ×4 → r_data 0xA1..0xA4 with valid one cycle after each pop (standard mode).
- From empty, pop → udf=1, valid stays 0, level 0. Then push+pop in the same cycle → level 1, no output.
- Fill to 3, then push+pop every cycle for 10 cycles → level constant 3, data in order, pointers wrap with no loss.
- Reset asserted with level 3 and flags set → next cycle level=0, ept=1, almost_ept=1, ovf=udf=0, valid=0.
- With PARAM_SYNC_FIFO_FWFT_EN, push 0x5A at N → valid=1, r_data=0x5A at N+1 without a pop. pop at N+1 → valid=0 at N+2.

Source files
------------

// File: rtl/param_sync_fifo_pkg.sv
// param_sync_fifo_pkg
// Shared definitions for the parametrised single-clock FIFO:
//   ptr_w()          pointer width for a given depth (clog2-based); the level
//                    counter is one bit wider so it can hold DEPTH itself.
//   fifo_status_t    registered status bundle
//                    {ept, ful, almost_ept, almost_ful, ovf, udf}.
package param_sync_fifo_pkg;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    typedef struct packed {
        logic ept;
        logic ful;
        logic almost_ept;
        logic almost_ful;
        logic ovf;
        logic udf;
    } fifo_status_t;

endpackage

// File: rtl/param_sync_fifo_mem.sv
// param_sync_fifo_mem
// DEPTH x WIDTH storage array: synchronous write, asynchronous read by address.
// Storage has no reset; the FIFO pointers and level define which entries are live.
// Ports:
//   clock   in   write clock (posedge)
//   we      in   write enable
//   waddr   in   write address
//   wdata   in   write data
//   raddr   in   read address
//   rdata   out  read data (combinational from raddr)
import param_sync_fifo_pkg::*;

module param_sync_fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       we,
    input  logic [ptr_w(DEPTH)-1:0]    waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic [ptr_w(DEPTH)-1:0]    raddr,
    output logic [WIDTH-1:0]           rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo
// Parametrised single-clock FIFO with occupancy count, almost-empty/almost-full
// thresholds and sticky overflow/underflow flags.
// Compile-time option: define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through
// reads (r_data shows the head, valid = !ept, pop acknowledges). Otherwise a pop
// produces a registered one-cycle valid pulse with the head word.
// Ports:
//   clock       in   sole clock, posedge
//   reset       in   synchronous active-high reset
//   push        in   write request
//   w_data      in   write data, sampled with push
//   pop         in   read request / acknowledge
//   r_data      out  read data
//   valid       out  r_data qualifier
//   ept, ful    out  empty / full
//   almost_ept  out  level <= AE_LVL
//   almost_ful  out  level >= AF_LVL
//   level       out  current occupancy
//   ovf, udf    out  sticky overflow / underflow, cleared only by reset
import param_sync_fifo_pkg::*;

module param_sync_fifo #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AE_LVL = 2,
    parameter int unsigned AF_LVL = DEPTH - 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        push,
    input  logic [WIDTH-1:0]            w_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            r_data,
    output logic                        valid,
    output logic                        ept,
    output logic                        ful,
    output logic                        almost_ept,
    output logic                        almost_ful,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        ovf,
    output logic                        udf
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned LW = PW + 1;

    localparam logic [LW-1:0] AE_L  = LW'(AE_LVL);
    localparam logic [LW-1:0] AF_L  = LW'(AF_LVL);
    localparam logic [LW-1:0] FULL_L = LW'(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q,  level_d;
    fifo_status_t     status_q, status_d;
    logic             push_acc, pop_acc;
    logic [WIDTH-1:0] mem_rdata;

    param_sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock (clock),
        .we    (push_acc && !reset),
        .waddr (wr_ptr_q),
        .wdata (w_data),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    always_comb begin
        // A pop frees a slot in the same edge, so a push while full is still
        // accepted when paired with an accepted pop.
        pop_acc  = pop && !status_q.ept;
        push_acc = push && (!status_q.ful || pop_acc);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_acc && !pop_acc) begin
            level_d = level_q + 1'b1;
        end else if (pop_acc && !push_acc) begin
            level_d = level_q - 1'b1;
        end

        // Flags come from next-state level so they line up with level.
        status_d.ept        = (level_d == '0);
        status_d.ful        = (level_d == FULL_L);
        status_d.almost_ept = (level_d <= AE_L);
        status_d.almost_ful = (level_d >= AF_L);
        status_d.ovf        = status_q.ovf || (push && !push_acc);
        status_d.udf        = status_q.udf || (pop && status_q.ept);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            status_q <= '{ept: 1'b1, ful: 1'b0, almost_ept: 1'b1,
                          almost_ful: 1'b0, ovf: 1'b0, udf: 1'b0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            status_q <= status_d;
        end
    end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    // Head entry shown directly; forced to zero while empty so stale storage
    // never leaks onto r_data.
    assign r_data = status_q.ept ? '0 : mem_rdata;
    assign valid  = !status_q.ept;
`else
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             valid_q, valid_d;

    always_comb begin
        rdata_d = rdata_q;
        valid_d = pop_acc;
        if (pop_acc) begin
            rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= '0;
            valid_q <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            valid_q <= valid_d;
        end
    end

    assign r_data = rdata_q;
    assign valid  = valid_q;
`endif

    assign level      = level_q;
    assign ept        = status_q.ept;
    assign ful        = status_q.ful;
    assign almost_ept = status_q.almost_ept;
    assign almost_ful = status_q.almost_ful;
    assign ovf        = status_q.ovf;
    assign udf        = status_q.udf;

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo
// Directed bench for param_sync_fifo at WIDTH=8, DEPTH=4, AE_LVL=1, AF_LVL=3.
// Inputs change 1ns after posedge; outputs are checked at that same point,
// i.e. they reflect the edge just taken.
module tb_param_sync_fifo;

    logic       clock = 1'b0;
    logic       reset;
    logic       push;
    logic [7:0] w_data;
    logic       pop;
    logic [7:0] r_data;
    logic       valid;
    logic       ept, ful, almost_ept, almost_ful, ovf, udf;
    logic [2:0] level;

    int unsigned tests = 0;
    int unsigned fails = 0;

    param_sync_fifo #(
        .WIDTH  (8),
        .DEPTH  (4),
        .AE_LVL (1),
        .AF_LVL (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .w_data     (w_data),
        .pop        (pop),
        .r_data     (r_data),
        .valid      (valid),
        .ept        (ept),
        .ful        (ful),
        .almost_ept (almost_ept),
        .almost_ful (almost_ful),
        .level      (level),
        .ovf        (ovf),
        .udf        (udf)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; push = 1'b0; pop = 1'b0; w_data = '0;
        step(); step();
        reset = 1'b0;
        tests++; if (level !== 3'd0) begin fails++; $display("FAIL reset_level got %0d exp 0", level); end
        tests++; if ({ept, ful, almost_ept, almost_ful, ovf, udf} !== 6'b101000) begin
            fails++; $display("FAIL reset_flags got %b exp 101000", {ept, ful, almost_ept, almost_ful, ovf, udf}); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", valid); end
        tests++; if (r_data !== 8'h00) begin fails++; $display("FAIL reset_rdata got %h exp 00", r_data); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; w_data = 8'hA1 + 8'(i);
            step();
            tests++; if (level !== 3'(i + 1)) begin fails++; $display("FAIL fill_level[%0d] got %0d exp %0d", i, level, i + 1); end
            tests++; if ({ept, ful, almost_ept, almost_ful} !== {1'b0, i == 3, i == 0, i >= 2}) begin
                fails++; $display("FAIL fill_flags[%0d] got %b exp %b", i, {ept, ful, almost_ept, almost_ful}, {1'b0, i == 3, i == 0, i >= 2}); end
        end
        push = 1'b0;
    endtask

    task automatic test_overflow_drain();
        push = 1'b1; w_data = 8'hFF;
        step();
        push = 1'b0;
        tests++; if (ovf !== 1'b1 || level !== 3'd4 || ful !== 1'b1) begin
            fails++; $display("FAIL ovf got ovf=%b level=%0d ful=%b exp 1/4/1", ovf, level, ful); end
        for (int i = 0; i < 4; i++) begin
            pop = 1'b1;
            step();
            tests++; if (valid !== 1'b1 || r_data !== 8'hA1 + 8'(i) || level !== 3'(3 - i)) begin
                fails++; $display("FAIL drain[%0d] got valid=%b data=%h level=%0d exp 1/%h/%0d", i, valid, r_data, level, 8'hA1 + 8'(i), 3 - i); end
        end
        pop = 1'b0;
        step();
        tests++; if (valid !== 1'b0 || r_data !== 8'hA4 || ept !== 1'b1 || udf !== 1'b0) begin
            fails++; $display("FAIL drain_idle got valid=%b data=%h ept=%b udf=%b exp 0/a4/1/0", valid, r_data, ept, udf); end
    endtask

    task automatic test_underflow();
        pop = 1'b1;
        step();
        tests++; if (udf !== 1'b1 || valid !== 1'b0 || level !== 3'd0) begin
            fails++; $display("FAIL udf got udf=%b valid=%b level=%0d exp 1/0/0", udf, valid, level); end
        push = 1'b1; w_data = 8'h33;
        step();
        push = 1'b0;
        tests++; if (level !== 3'd1 || valid !== 1'b0 || ept !== 1'b0) begin
            fails++; $display("FAIL empty_pushpop got level=%0d valid=%b ept=%b exp 1/0/0", level, valid, ept); end
        step();
        pop = 1'b0;
        tests++; if (valid !== 1'b1 || r_data !== 8'h33 || level !== 3'd0) begin
            fails++; $display("FAIL empty_pushpop_read got valid=%b data=%h level=%0d exp 1/33/0", valid, r_data, level); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; w_data = 8'h10 + 8'(i);
            step();
        end
        pop = 1'b1;
        for (int i = 0; i < 10; i++) begin
            w_data = 8'h13 + 8'(i);
            step();
            tests++; if (valid !== 1'b1 || r_data !== 8'h10 + 8'(i) || level !== 3'd3) begin
                fails++; $display("FAIL b2b[%0d] got valid=%b data=%h level=%0d exp 1/%h/3", i, valid, r_data, level, 8'h10 + 8'(i)); end
        end
        push = 1'b0; pop = 1'b0;
    endtask

    task automatic test_mid_reset();
        push = 1'b1; pop = 1'b1; reset = 1'b1; w_data = 8'hEE;
        step();
        reset = 1'b0; push = 1'b0; pop = 1'b0;
        tests++; if (level !== 3'd0 || {ept, ful, almost_ept, almost_ful, ovf, udf} !== 6'b101000) begin
            fails++; $display("FAIL mid_reset got level=%0d flags=%b exp 0/101000", level, {ept, ful, almost_ept, almost_ful, ovf, udf}); end
        tests++; if (valid !== 1'b0 || r_data !== 8'h00) begin
            fails++; $display("FAIL mid_reset_read got valid=%b data=%h exp 0/00", valid, r_data); end
        push = 1'b1; w_data = 8'h77;
        step();
        push = 1'b0; pop = 1'b1;
        step();
        pop = 1'b0;
        tests++; if (valid !== 1'b1 || r_data !== 8'h77 || level !== 3'd0) begin
            fails++; $display("FAIL post_reset_read got valid=%b data=%h level=%0d exp 1/77/0", valid, r_data, level); end
    endtask

    task automatic test_full_pushpop();
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; w_data = 8'h41 + 8'(i);
            step();
        end
        pop = 1'b1; w_data = 8'h45;
        step();
        push = 1'b0; pop = 1'b0;
        tests++; if (level !== 3'd4 || ful !== 1'b1 || ovf !== 1'b0 || valid !== 1'b1 || r_data !== 8'h41) begin
            fails++; $display("FAIL full_pushpop got level=%0d ful=%b ovf=%b valid=%b data=%h exp 4/1/0/1/41", level, ful, ovf, valid, r_data); end
        pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++; if (r_data !== 8'h42 + 8'(i)) begin
                fails++; $display("FAIL full_pushpop_drain[%0d] got %h exp %h", i, r_data, 8'h42 + 8'(i)); end
        end
        pop = 1'b0;
    endtask

    task automatic test_fwft();
        reset = 1'b1;
        step();
        reset = 1'b0; push = 1'b1; w_data = 8'h5A;
        step();
        push = 1'b0;
        tests++; if (valid !== 1'b1 || r_data !== 8'h5A) begin
            fails++; $display("FAIL fwft_show got valid=%b data=%h exp 1/5a", valid, r_data); end
        pop = 1'b1;
        step();
        pop = 1'b0;
        tests++; if (valid !== 1'b0 || ept !== 1'b1 || r_data !== 8'h00) begin
            fails++; $display("FAIL fwft_ack got valid=%b ept=%b data=%h exp 0/1/00", valid, ept, r_data); end
    endtask

    initial begin
        test_reset();
        test_fill();
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        test_fwft();
`else
        test_overflow_drain();
        test_underflow();
        test_back_to_back();
        test_mid_reset();
        test_full_pushpop();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
